// File: rtl/ccd_pattern_tx.sv
// ---------------------------------------------------------------------------
// ccd_pattern_tx
//
// Synthetic D5M-style camera source. It produces 12-bit Bayer raw pixels with
// FVAL/LVAL framing on the pixel clock. It stands in for the camera pins at
// the registered-input point of the capture path, so that capture, RAW-to-RGB
// and the SDRAM writer can be brought up without a sensor attached.
//
// Ports:
//   iCLK        in   1   pixel clock
//   iRST_N      in   1   synchronous active-low reset
//   iEN         in   1   run request (level); a started frame always completes
//   iMODE       in   2   pattern select, latched at each frame start
//                         0 horizontal ramp, 1 vertical ramp, 2 red field,
//                         3 LFSR noise / mid-grey constant
//   oDATA       out  12  pixel data, 0 whenever oLVAL is low
//   oFVAL       out  1   frame valid
//   oLVAL       out  1   line valid
//   oFRAME_CNT  out  16  completed-frame count (wraps)
//   oBUSY       out  1   high whenever the sequencer is not idle
//
// Build option:
//   CCD_TX_LFSR_EN  when defined, mode 3 emits the low 12 bits of a 16-bit
//                   Fibonacci LFSR (taps 16,14,13,11) reseeded to 0xACE1 at
//                   every frame start. When undefined no LFSR is built and
//                   mode 3 emits a constant 0x800.
// ---------------------------------------------------------------------------
module ccd_pattern_tx #(
   parameter int H_ACTIVE  = 1280,
   parameter int V_ACTIVE  = 960,
   parameter int FV2LV     = 4,
   parameter int HBLANK    = 16,
   parameter int LV2FV     = 4,
   parameter int FRAME_GAP = 32
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iEN,
   input  logic [1:0]  iMODE,
   output logic [11:0] oDATA,
   output logic        oFVAL,
   output logic        oLVAL,
   output logic [15:0] oFRAME_CNT,
   output logic        oBUSY
);

   typedef enum logic [2:0] {
      IDLE,
      FV_PRE,
      LINE,
      HBLK,
      FV_POST,
      GAP
   } state_t;

   localparam logic [11:0] X_LAST      = 12'(H_ACTIVE - 1);
   localparam logic [11:0] Y_LAST      = 12'(V_ACTIVE - 1);
   localparam logic [31:0] FV2LV_LAST  = 32'(FV2LV - 1);
   localparam logic [31:0] HBLANK_LAST = 32'(HBLANK - 1);
   localparam logic [31:0] LV2FV_LAST  = 32'(LV2FV - 1);
   localparam logic [31:0] GAP_LAST    = 32'(FRAME_GAP - 1);

   state_t      state;
   logic [11:0] x;
   logic [11:0] y;
   logic [31:0] phase;
   logic [1:0]  mode;
   logic [11:0] pix;

`ifdef CCD_TX_LFSR_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   logic [15:0] lfsr;
   logic        lfsr_fb;

   // Right-shifting Fibonacci form: bits 0,2,3,5 correspond to taps 16,14,13,11.
   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
`endif

   // Pixel value for the current (x, y) under the mode latched for this frame.
   // Bayer row 0 is G1 R G1 R ..., so only even-row/odd-column sites are red.
   always_comb begin
      pix = 12'h000;
      unique case (mode)
         2'd0: pix = x;
         2'd1: pix = y;
         2'd2: pix = (!y[0] && x[0]) ? 12'hFFF : 12'h000;
         2'd3: begin
`ifdef CCD_TX_LFSR_EN
            pix = lfsr[11:0];
`else
            pix = 12'h800;
`endif
         end
         default: pix = 12'h000;
      endcase
   end

   // Frame sequencer. The output registers are loaded from the state as it
   // stands before each edge, so every output trails the state by one cycle;
   // this gives the one-cycle gap between sampling iEN and FVAL rising, while
   // keeping LVAL and the first pixel aligned. The phase counter is shared by
   // all the blanking states because only one of them is ever active.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state      <= IDLE;
         x          <= '0;
         y          <= '0;
         phase      <= '0;
         mode       <= '0;
         oDATA      <= '0;
         oFVAL      <= 1'b0;
         oLVAL      <= 1'b0;
         oBUSY      <= 1'b0;
         oFRAME_CNT <= '0;
`ifdef CCD_TX_LFSR_EN
         lfsr       <= LFSR_SEED;
`endif
      end else begin
         oFVAL <= (state == FV_PRE) || (state == LINE) ||
                  (state == HBLK)   || (state == FV_POST);
         oLVAL <= (state == LINE);
         oBUSY <= (state != IDLE);
         oDATA <= (state == LINE) ? pix : 12'h000;

`ifdef CCD_TX_LFSR_EN
         // Advancing only on active pixels keeps every frame bit-identical.
         if (state == LINE) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
         end
`endif

         unique case (state)
            IDLE: begin
               phase <= '0;
               if (iEN) begin
                  state <= FV_PRE;
                  mode  <= iMODE;
`ifdef CCD_TX_LFSR_EN
                  lfsr  <= LFSR_SEED;
`endif
               end
            end

            FV_PRE: begin
               if (phase == FV2LV_LAST) begin
                  phase <= '0;
                  x     <= '0;
                  y     <= '0;
                  state <= LINE;
               end else begin
                  phase <= phase + 32'd1;
               end
            end

            LINE: begin
               if (x == X_LAST) begin
                  x     <= '0;
                  phase <= '0;
                  if (y == Y_LAST) begin
                     y     <= '0;
                     state <= FV_POST;
                  end else begin
                     y     <= y + 12'd1;
                     state <= HBLK;
                  end
               end else begin
                  x <= x + 12'd1;
               end
            end

            HBLK: begin
               if (phase == HBLANK_LAST) begin
                  phase <= '0;
                  state <= LINE;
               end else begin
                  phase <= phase + 32'd1;
               end
            end

            FV_POST: begin
               if (phase == LV2FV_LAST) begin
                  phase      <= '0;
                  oFRAME_CNT <= oFRAME_CNT + 16'd1;
                  state      <= GAP;
               end else begin
                  phase <= phase + 32'd1;
               end
            end

            GAP: begin
               // iEN is only looked at here, so a frame can never be cut short.
               if (phase == GAP_LAST) begin
                  phase <= '0;
                  if (iEN) begin
                     state <= FV_PRE;
                     mode  <= iMODE;
`ifdef CCD_TX_LFSR_EN
                     lfsr  <= LFSR_SEED;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  phase <= phase + 32'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccd_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_ccd_pattern_tx
//
// Bench for ccd_pattern_tx with a small frame geometry (8x4 pixels, FV2LV=2,
// HBLANK=3, LV2FV=2, FRAME_GAP=5). Whole frames are recorded sample by sample,
// with index 0 being the first FVAL-high cycle, and then compared against a
// table of hand-computed points plus a few frame-shape totals.
// Mode-3 expectations follow the CCD_TX_LFSR_EN build option.
// ---------------------------------------------------------------------------
module tb_ccd_pattern_tx;

   localparam int H_ACTIVE  = 8;
   localparam int V_ACTIVE  = 4;
   localparam int FV2LV     = 2;
   localparam int HBLANK    = 3;
   localparam int LV2FV     = 2;
   localparam int FRAME_GAP = 5;
   localparam int NFRAMES   = 7;
   localparam int NSAMP     = 51;

`ifdef CCD_TX_LFSR_EN
   localparam logic [11:0] M3_T2 = 12'hCE1;
   localparam logic [11:0] M3_T3 = 12'h670;
   localparam logic [11:0] M3_T4 = 12'hB38;
   localparam logic [11:0] M3_T5 = 12'h59C;
`else
   localparam logic [11:0] M3_T2 = 12'h800;
   localparam logic [11:0] M3_T3 = 12'h800;
   localparam logic [11:0] M3_T4 = 12'h800;
   localparam logic [11:0] M3_T5 = 12'h800;
`endif

   logic        iCLK;
   logic        iRST_N;
   logic        iEN;
   logic [1:0]  iMODE;
   logic [11:0] oDATA;
   logic        oFVAL;
   logic        oLVAL;
   logic [15:0] oFRAME_CNT;
   logic        oBUSY;

   typedef struct {
      int          frame;
      int          t;
      logic        fval;
      logic        lval;
      logic [11:0] data;
      int          cnt;
   } vec_t;

   vec_t        vecs[$];
   logic        cap_fval [0:NFRAMES-1][0:NSAMP-1];
   logic        cap_lval [0:NFRAMES-1][0:NSAMP-1];
   logic        cap_busy [0:NFRAMES-1][0:NSAMP-1];
   logic [11:0] cap_data [0:NFRAMES-1][0:NSAMP-1];
   logic [15:0] cap_cnt  [0:NFRAMES-1][0:NSAMP-1];

   int nVec;
   int nMis;

   ccd_pattern_tx #(
      .H_ACTIVE  (H_ACTIVE),
      .V_ACTIVE  (V_ACTIVE),
      .FV2LV     (FV2LV),
      .HBLANK    (HBLANK),
      .LV2FV     (LV2FV),
      .FRAME_GAP (FRAME_GAP)
   ) dut (
      .iCLK       (iCLK),
      .iRST_N     (iRST_N),
      .iEN        (iEN),
      .iMODE      (iMODE),
      .oDATA      (oDATA),
      .oFVAL      (oFVAL),
      .oLVAL      (oLVAL),
      .oFRAME_CNT (oFRAME_CNT),
      .oBUSY      (oBUSY)
   );

   // Free-running pixel clock, 10 time units per period.
   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      nVec++;
      if (actual != expected) begin
         nMis++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic addVec(input int frame, input int t, input logic fval, input logic lval,
                         input logic [11:0] data, input int cnt);
      vec_t v;
      v.frame = frame;
      v.t     = t;
      v.fval  = fval;
      v.lval  = lval;
      v.data  = data;
      v.cnt   = cnt;
      vecs.push_back(v);
   endtask

   // Entered on the negedge holding the first FVAL-high sample; leaves on the
   // negedge of index NSAMP-1, i.e. where the next frame would show FVAL high.
   task automatic applyStimulus(input int frame, input int chg_t, input logic [1:0] chg_mode,
                                input int drop_t);
      for (int i = 0; i < NSAMP; i++) begin
         if (i > 0) @(negedge iCLK);
         cap_fval[frame][i] = oFVAL;
         cap_lval[frame][i] = oLVAL;
         cap_busy[frame][i] = oBUSY;
         cap_data[frame][i] = oDATA;
         cap_cnt[frame][i]  = oFRAME_CNT;
         if (i == chg_t)  iMODE = chg_mode;
         if (i == drop_t) iEN = 1'b0;
      end
   endtask

   task automatic waitRise(input string name);
      logic prev;
      bit   seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         prev = oFVAL;
         @(negedge iCLK);
         if (oFVAL && !prev) seen = 1'b1;
      end
      checkOutput({name, " fval rise seen"}, int'(seen), 1);
   endtask

   // Frame-shape totals over one recorded frame.
   task automatic checkShape(input int f, input logic next_fval);
      int fvHigh;
      int lvHigh;
      int lvRises;
      int dirty;
      fvHigh  = 0;
      lvHigh  = 0;
      lvRises = 0;
      dirty   = 0;
      for (int i = 0; i < NSAMP - 1; i++) begin
         if (cap_fval[f][i]) fvHigh++;
         if (cap_lval[f][i]) lvHigh++;
         if (cap_lval[f][i] && (i == 0 || !cap_lval[f][i-1])) lvRises++;
         if (!cap_lval[f][i] && cap_data[f][i] != 12'h000) dirty++;
      end
      checkOutput($sformatf("f%0d fval high length", f), fvHigh, 45);
      checkOutput($sformatf("f%0d lval high cycles", f), lvHigh, 32);
      checkOutput($sformatf("f%0d lval pulses", f), lvRises, 4);
      checkOutput($sformatf("f%0d data nonzero outside lval", f), dirty, 0);
      checkOutput($sformatf("f%0d fval at period 50", f), int'(cap_fval[f][NSAMP-1]), int'(next_fval));
   endtask

   initial begin
      nVec   = 0;
      nMis   = 0;
      iRST_N = 1'b0;
      iEN    = 1'b0;
      iMODE  = 2'd0;

      // Hand-computed points. Frame timeline: t0-1 FV_PRE, lines at t2-9,
      // t13-20, t24-31, t35-42, HBLANK between, t43-44 FV_POST, t45-49 gap.
      // Frame 0 mode 0 (ramp in x); frame counter starts at 0.
      addVec(0, 0,  1, 0, 12'h000, 0);
      addVec(0, 1,  1, 0, 12'h000, -1);
      addVec(0, 2,  1, 1, 12'h000, -1);
      addVec(0, 5,  1, 1, 12'h003, -1);
      addVec(0, 9,  1, 1, 12'h007, -1);
      addVec(0, 10, 1, 0, 12'h000, -1);
      addVec(0, 12, 1, 0, 12'h000, -1);
      addVec(0, 13, 1, 1, 12'h000, -1);
      addVec(0, 42, 1, 1, 12'h007, -1);
      addVec(0, 44, 1, 0, 12'h000, -1);
      addVec(0, 45, 0, 0, 12'h000, 1);
      addVec(0, 49, 0, 0, 12'h000, -1);
      // Frame 1 mode 1 (line index), iEN dropped during line 1.
      addVec(1, 2,  1, 1, 12'h000, -1);
      addVec(1, 13, 1, 1, 12'h001, -1);
      addVec(1, 27, 1, 1, 12'h002, -1);
      addVec(1, 42, 1, 1, 12'h003, -1);
      addVec(1, 45, 0, 0, 12'h000, 2);
      addVec(1, 50, 0, 0, 12'h000, 2);
      // Frame 2 mode 2 (red field).
      addVec(2, 2,  1, 1, 12'h000, -1);
      addVec(2, 3,  1, 1, 12'hFFF, -1);
      addVec(2, 4,  1, 1, 12'h000, -1);
      addVec(2, 9,  1, 1, 12'hFFF, -1);
      addVec(2, 13, 1, 1, 12'h000, -1);
      addVec(2, 14, 1, 1, 12'h000, -1);
      addVec(2, 20, 1, 1, 12'h000, -1);
      addVec(2, 25, 1, 1, 12'hFFF, -1);
      addVec(2, 36, 1, 1, 12'h000, -1);
      addVec(2, 42, 1, 1, 12'h000, 2);
      addVec(2, 45, 0, 0, 12'h000, 3);
      // Frames 3 and 4 mode 3, each reseeded.
      for (int f = 3; f <= 4; f++) begin
         addVec(f, 2, 1, 1, M3_T2, -1);
         addVec(f, 3, 1, 1, M3_T3, -1);
         addVec(f, 4, 1, 1, M3_T4, -1);
         addVec(f, 5, 1, 1, M3_T5, -1);
      end
      addVec(4, 45, 0, 0, 12'h000, 5);
      // Frame 6: first frame after the mid-line reset, mode 0 again.
      addVec(6, 0,  1, 0, 12'h000, 0);
      addVec(6, 2,  1, 1, 12'h000, -1);
      addVec(6, 3,  1, 1, 12'h001, -1);
      addVec(6, 13, 1, 1, 12'h000, -1);
      addVec(6, 45, 0, 0, 12'h000, 1);

      // Reset values.
      repeat (3) @(negedge iCLK);
      checkOutput("reset oDATA", int'(oDATA), 0);
      checkOutput("reset oFVAL", int'(oFVAL), 0);
      checkOutput("reset oLVAL", int'(oLVAL), 0);
      checkOutput("reset oBUSY", int'(oBUSY), 0);
      checkOutput("reset oFRAME_CNT", int'(oFRAME_CNT), 0);
      iRST_N = 1'b1;
      @(negedge iCLK);

      // Start latency: iEN seen at edge 0, FVAL/BUSY high after edge 1.
      iEN   = 1'b1;
      iMODE = 2'd0;
      @(negedge iCLK);
      checkOutput("start fval after edge 0", int'(oFVAL), 0);
      checkOutput("start busy after edge 0", int'(oBUSY), 0);
      @(negedge iCLK);
      checkOutput("start fval after edge 1", int'(oFVAL), 1);
      checkOutput("start busy after edge 1", int'(oBUSY), 1);

      // Frame 0 mode 0, mode switched to 1 mid-frame (applies to frame 1).
      applyStimulus(0, 20, 2'd1, -1);
      // Frame 1 mode 1, run request dropped during line 1.
      applyStimulus(1, -1, 2'd1, 15);
      checkOutput("idle after drop busy", int'(cap_busy[1][50]), 0);
      checkOutput("gap busy", int'(cap_busy[1][47]), 1);

      // Restart in mode 2, switch to mode 3 mid-frame.
      iEN   = 1'b1;
      iMODE = 2'd2;
      waitRise("restart");
      applyStimulus(2, 20, 2'd3, -1);
      applyStimulus(3, -1, 2'd3, -1);
      applyStimulus(4, 20, 2'd0, -1);

      // Frame 5 starts; reset for one cycle in the middle of line 0.
      repeat (5) @(negedge iCLK);
      checkOutput("pre-reset lval", int'(oLVAL), 1);
      iRST_N = 1'b0;
      @(negedge iCLK);
      checkOutput("mid reset oDATA", int'(oDATA), 0);
      checkOutput("mid reset oFVAL", int'(oFVAL), 0);
      checkOutput("mid reset oLVAL", int'(oLVAL), 0);
      checkOutput("mid reset oBUSY", int'(oBUSY), 0);
      checkOutput("mid reset oFRAME_CNT", int'(oFRAME_CNT), 0);
      iRST_N = 1'b1;
      waitRise("post-reset");
      applyStimulus(6, -1, 2'd0, -1);

      // Compare every recorded frame against the table and shape totals.
      foreach (vecs[k]) begin
         checkOutput($sformatf("f%0d t%0d fval", vecs[k].frame, vecs[k].t),
                     int'(cap_fval[vecs[k].frame][vecs[k].t]), int'(vecs[k].fval));
         checkOutput($sformatf("f%0d t%0d lval", vecs[k].frame, vecs[k].t),
                     int'(cap_lval[vecs[k].frame][vecs[k].t]), int'(vecs[k].lval));
         checkOutput($sformatf("f%0d t%0d data", vecs[k].frame, vecs[k].t),
                     int'(cap_data[vecs[k].frame][vecs[k].t]), int'(vecs[k].data));
         if (vecs[k].cnt >= 0) begin
            checkOutput($sformatf("f%0d t%0d frame_cnt", vecs[k].frame, vecs[k].t),
                        int'(cap_cnt[vecs[k].frame][vecs[k].t]), vecs[k].cnt);
         end
      end
      checkShape(0, 1'b1);
      checkShape(1, 1'b0);
      checkShape(2, 1'b1);
      checkShape(3, 1'b1);
      checkShape(4, 1'b1);
      checkShape(6, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
